// File: rtl/shift_register_dyn_if.sv
// Bus bundle for shift_register_dyn: control, serial data, tap address and all
// data/status outputs. clk_in and rst_in stay plain ports on the module.
interface shift_register_dyn_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              clk_en;
  logic              clr_in;
  logic [1:0]        mode_in;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] tap_addr_in;
  logic [DATA_W-1:0] tap_out;
  logic              tap_valid_out;
  logic [DATA_W-1:0] dout_hi;
  logic [DATA_W-1:0] dout_lo;
  logic [ADDR_W:0]   fill_out;
  logic              full_out;

  modport master (
    output clk_en, clr_in, mode_in, data_in, tap_addr_in,
    input  tap_out, tap_valid_out, dout_hi, dout_lo, fill_out, full_out
  );

  modport slave (
    input  clk_en, clr_in, mode_in, data_in, tap_addr_in,
    output tap_out, tap_valid_out, dout_hi, dout_lo, fill_out, full_out
  );
endinterface

// File: rtl/shift_register_dyn.sv
// DEPTH x DATA_W shift register with shift up/down, rotate and hold modes,
// a registered dynamically addressed tap, fill counter and full flag.
module shift_register_dyn #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  shift_register_dyn_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_ROT  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  mode_e             mode;
  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [DATA_W-1:0] tap_q, tap_d;
  logic              tap_valid_q, tap_valid_d;
  dir_e              dir_q, dir_d;

  logic [ADDR_W:0]   addr_ext;
  logic              addr_in_range;
  logic [DATA_W-1:0] tap_word;
  dir_e              rule_dir;
  logic              up_valid;
  logic              down_valid;

  assign mode = mode_e'(bus.mode_in);

  // Tap read mux over the pre-edge stage contents.
  always_comb begin
    addr_ext      = {1'b0, bus.tap_addr_in};
    addr_in_range = addr_ext < DEPTH_C;
    tap_word      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.tap_addr_in == ADDR_W'(i)) tap_word = stage_q[i];
    end
  end

  // Valid-window rule: hold falls back to the direction of the last shift.
  always_comb begin
    rule_dir = dir_q;
    case (mode)
      MODE_UP, MODE_ROT: rule_dir = DIR_UP;
      MODE_DOWN:         rule_dir = DIR_DOWN;
      default:           rule_dir = dir_q;
    endcase
    up_valid   = addr_ext < fill_q;
    down_valid = addr_ext >= (DEPTH_C - fill_q);
  end

  always_comb begin
    tap_d       = addr_in_range ? tap_word : '0;
    tap_valid_d = addr_in_range && ((rule_dir == DIR_DOWN) ? down_valid : up_valid);
    if (bus.clr_in) begin
      tap_d       = '0;
      tap_valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    fill_d = fill_q;
    dir_d  = dir_q;
    if (bus.clr_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
      fill_d = '0;
    end else if (bus.clk_en) begin
      case (mode)
        MODE_UP: begin
          stage_d[0] = bus.data_in;
          for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
          if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
          dir_d = DIR_UP;
        end
        MODE_DOWN: begin
          stage_d[DEPTH-1] = bus.data_in;
          for (int unsigned i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
          if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
          dir_d = DIR_DOWN;
        end
        MODE_ROT: begin
          stage_d[0] = stage_q[DEPTH-1];
          for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
          dir_d = DIR_UP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      fill_q      <= '0;
      tap_q       <= '0;
      tap_valid_q <= 1'b0;
      dir_q       <= DIR_UP;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      fill_q      <= fill_d;
      tap_q       <= tap_d;
      tap_valid_q <= tap_valid_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.tap_out       = tap_q;
  assign bus.tap_valid_out = tap_valid_q;
  assign bus.dout_hi       = stage_q[DEPTH-1];
  assign bus.dout_lo       = stage_q[0];
  assign bus.fill_out      = fill_q;
  assign bus.full_out      = (fill_q == DEPTH_C);

endmodule

// File: tb/tb_shift_register_dyn.sv
// Bench for shift_register_dyn: DEPTH=32 and DEPTH=20 instances share stimulus
// and are checked against a queue-based reference model.
module tb_shift_register_dyn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] din  = 8'h00;
  logic [4:0] addr = 5'd0;

  always #5 clk = ~clk;

  shift_register_dyn_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();
  shift_register_dyn_if #(.DATA_W(8), .ADDR_W(5)) bus_b ();

  assign bus_a.clk_en = en;   assign bus_b.clk_en = en;
  assign bus_a.clr_in = clr;  assign bus_b.clr_in = clr;
  assign bus_a.mode_in = mode; assign bus_b.mode_in = mode;
  assign bus_a.data_in = din; assign bus_b.data_in = din;
  assign bus_a.tap_addr_in = addr; assign bus_b.tap_addr_in = addr;

  shift_register_dyn #(.DATA_W(8), .DEPTH(32), .ADDR_W(5)) dut_a (
    .clk_in(clk), .rst_in(rst), .bus(bus_a)
  );
  shift_register_dyn #(.DATA_W(8), .DEPTH(20), .ADDR_W(5)) dut_b (
    .clk_in(clk), .rst_in(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  int         depth [2] = '{32, 20};
  logic [7:0] mq    [2][$];
  int         fill  [2];
  bit         last_down [2];
  logic [7:0] m_tap [2];
  bit         m_tapv [2];
  logic [7:0] first_word;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero(input int k);
    mq[k].delete();
    for (int i = 0; i < depth[k]; i++) mq[k].push_back(8'h00);
    fill[k]   = 0;
    m_tap[k]  = 8'h00;
    m_tapv[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_zero(k);
      last_down[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int d;
      bit down_rule;
      logic [7:0] w;
      d = depth[k];
      if (clr) begin
        model_zero(k);
      end else begin
        down_rule = (mode == 2'b01) || (mode == 2'b11 && last_down[k]);
        if (int'(addr) >= d) begin
          m_tap[k]  = 8'h00;
          m_tapv[k] = 1'b0;
        end else begin
          m_tap[k]  = mq[k][addr];
          m_tapv[k] = down_rule ? (int'(addr) >= d - fill[k]) : (int'(addr) < fill[k]);
        end
        if (en) begin
          case (mode)
            2'b00: begin
              mq[k].push_front(din); w = mq[k].pop_back();
              if (fill[k] < d) fill[k]++;
              last_down[k] = 1'b0;
            end
            2'b01: begin
              mq[k].push_back(din); w = mq[k].pop_front();
              if (fill[k] < d) fill[k]++;
              last_down[k] = 1'b1;
            end
            2'b10: begin
              w = mq[k].pop_back(); mq[k].push_front(w);
              last_down[k] = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    cmp({ph, ".a.tap"},   32'(bus_a.tap_out),       32'(m_tap[0]));
    cmp({ph, ".a.tapv"},  32'(bus_a.tap_valid_out), 32'(m_tapv[0]));
    cmp({ph, ".a.hi"},    32'(bus_a.dout_hi),       32'(mq[0][31]));
    cmp({ph, ".a.lo"},    32'(bus_a.dout_lo),       32'(mq[0][0]));
    cmp({ph, ".a.fill"},  32'(bus_a.fill_out),      32'(fill[0]));
    cmp({ph, ".a.full"},  32'(bus_a.full_out),      32'(fill[0] == 32));
    cmp({ph, ".b.tap"},   32'(bus_b.tap_out),       32'(m_tap[1]));
    cmp({ph, ".b.tapv"},  32'(bus_b.tap_valid_out), 32'(m_tapv[1]));
    cmp({ph, ".b.hi"},    32'(bus_b.dout_hi),       32'(mq[1][19]));
    cmp({ph, ".b.lo"},    32'(bus_b.dout_lo),       32'(mq[1][0]));
    cmp({ph, ".b.fill"},  32'(bus_b.fill_out),      32'(fill[1]));
    cmp({ph, ".b.full"},  32'(bus_b.full_out),      32'(fill[1] == 20));
  endtask

  task automatic step(input string ph, input bit e, input bit c, input logic [1:0] m,
                      input logic [7:0] d, input logic [4:0] a);
    en = e; clr = c; mode = m; din = d; addr = a;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Shift-up latency: word 1 lands on tap 5 after edge 7, dout_hi after edge 32.
    for (int i = 1; i <= 40; i++) begin
      step("shup", 1'b1, 1'b0, 2'b00, 8'(i), 5'd5);
      if (i == 7)  cmp("shup.tap_e7", 32'(bus_a.tap_out), 32'd1);
      if (i == 32) cmp("shup.hi_e32", 32'(bus_a.dout_hi), 32'd1);
    end

    // Asynchronous reset mid-stream, observed without a clock edge.
    #3 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("post_rst", 1'b1, 1'b0, 2'b00, 8'h5C, 5'd0);

    // Shift-down load then full rotation.
    step("clr0", 1'b0, 1'b1, 2'b00, 8'h00, 5'd0);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if (i == 0) first_word = w;
      step("shdn", 1'b1, 1'b0, 2'b01, w, 5'(i));
    end
    cmp("shdn.first_lo", 32'(bus_a.dout_lo), 32'(first_word));
    for (int i = 0; i < 32; i++) step("rot", 1'b1, 1'b0, 2'b10, 8'($urandom), 5'($urandom_range(0, 31)));
    cmp("rot.first_lo", 32'(bus_a.dout_lo), 32'(first_word));
    cmp("rot.fill", 32'(bus_a.fill_out), 32'd32);
    for (int i = 0; i < 8; i++) step("hold_dn", 1'b1, 1'b0, 2'b11, 8'hFF, 5'(i * 4));

    // clk_en gating with a fixed tap.
    for (int i = 0; i < 16; i++) step("gate", i[0] == 1'b0, 1'b0, 2'b00, 8'($urandom), 5'd3);

    // Clear priority over enable.
    step("clr1", 1'b1, 1'b1, 2'b00, 8'h11, 5'd0);
    for (int i = 0; i < 10; i++) step("fill10", 1'b1, 1'b0, 2'b00, 8'(8'h40 + i), 5'd2);
    cmp("fill10.a", 32'(bus_a.fill_out), 32'd10);
    step("clr_aa", 1'b1, 1'b1, 2'b00, 8'hAA, 5'd0);
    for (int i = 0; i < 32; i++) step("clr_scan", 1'b0, 1'b0, 2'b00, 8'h00, 5'(i));

    // Out-of-range tap on the 20-deep instance.
    for (int i = 0; i < 40; i++) step("ld_full", 1'b1, 1'b0, 2'b00, 8'($urandom), 5'd0);
    step("oor25", 1'b0, 1'b0, 2'b00, 8'h00, 5'd25);
    cmp("oor25.b.tap", 32'(bus_b.tap_out), 32'd0);
    step("tap19", 1'b0, 1'b0, 2'b00, 8'h00, 5'd19);

    // Randomized mix of modes, enables, clears and addresses.
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), 8'($urandom), 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
